// File: rtl/fifo_ft245_tx_pkg.sv
// ft245_pkg: shared types and constants for the FT245 transmit path.
//   state_t - transmit FSM encoding (also exported on the top-level state port)
//   SYNC0   - first line-header sync byte
//   SYNC1   - second line-header sync byte
package ft245_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        HDR2    = 3'd3,
        HDR3    = 3'd4,
        BYTE_HI = 3'd5,
        BYTE_LO = 3'd6
    } state_t;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

endpackage

// File: rtl/fifo_ft245_tx_line_counter.sv
// line_counter: pixel-within-line and line index counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : one pixel fully sent (advance pix_cnt)
//   pix_cnt    : pixel index inside the current line
//   line_cnt   : index of the current line, wraps at all-ones
//   pix_wrap   : pix_cnt is the last pixel of the line
module line_counter #(
    parameter int line_length = 768,
    parameter int line_bits   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    output logic [line_bits-1:0] pix_cnt,
    output logic [line_bits-1:0] line_cnt,
    output logic                 pix_wrap
);

    localparam logic [line_bits-1:0] last_pix = line_bits'(line_length - 1);

    assign pix_wrap = (pix_cnt == last_pix);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (adv) begin
            if (pix_wrap) begin
                pix_cnt  <= '0;
                // natural binary wrap at all-ones
                line_cnt <= line_cnt + 1'b1;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_ft245_tx.sv
// fifo_ft245_tx: pops 16-bit pixel words from a FWFT fifo and sends them as
// two bytes (MSB first) on the FT232H synchronous-245 transmit bus. A 4-byte
// header (AA 55 line_hi line_lo) precedes the first pixel of every line.
//   rclk, rrst_n : read-domain clock, asynchronous active-low reset
//   enable       : allow fetching new words
//   rdata/rempty : fifo word (valid while rempty=0) and empty flag
//   rinc         : fifo pop strobe, one cycle per word
//   txe_n        : FT232H tx space available (active low)
//   wr_n/ftdata  : registered FT232H write strobe and data
//   line_cnt     : index of the line being sent
//   state        : FSM state, for observation
//
// Handshake: a byte is pending while wr_n=0; it is accepted on a rising edge
// with wr_n=0 and txe_n=0. Until accepted, wr_n and ftdata hold. A fifo word
// is consumed on a rising edge with rinc=1 (captured into word_q that edge).
module fifo_ft245_tx
    import ft245_pkg::*;
#(
    parameter int line_length = 768,
    parameter int line_bits   = 16
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 enable,
    input  logic [15:0]          rdata,
    input  logic                 rempty,
    output logic                 rinc,
    input  logic                 txe_n,
    output logic                 wr_n,
    output logic [7:0]           ftdata,
    output logic [line_bits-1:0] line_cnt,
    output state_t               state
);

    state_t               state_d;
    logic                 wr_n_d;
    logic [7:0]           ftdata_d;
    logic [15:0]          word_q;
    logic                 run_q;
    logic                 accept;
    logic                 fetch;
    logic                 pix_adv;
    logic                 pix_wrap;
    logic                 hdr_next;
    logic [line_bits-1:0] pix_cnt;
    logic [15:0]          line16;

    assign accept  = ~wr_n & ~txe_n;
    assign fetch   = enable & ~rempty;
    assign pix_adv = (state == BYTE_LO) & accept;
    assign line16  = 16'(line_cnt);

    // In BYTE_LO the counter is about to advance, so a new line starts when
    // the current pixel is the last one; in IDLE the counter is already there.
    assign hdr_next = (state == BYTE_LO) ? pix_wrap : (pix_cnt == '0);

    line_counter #(
        .line_length (line_length),
        .line_bits   (line_bits)
    ) u_line_counter (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .adv      (pix_adv),
        .pix_cnt  (pix_cnt),
        .line_cnt (line_cnt),
        .pix_wrap (pix_wrap)
    );

    // State register with the registered bus outputs.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state  <= IDLE;
            wr_n   <= 1'b1;
            ftdata <= 8'h00;
            word_q <= 16'h0000;
            run_q  <= 1'b0;
        end else begin
            state  <= state_d;
            wr_n   <= wr_n_d;
            ftdata <= ftdata_d;
            run_q  <= 1'b1;
            if (rinc) begin
                word_q <= rdata;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state;
        wr_n_d   = wr_n;
        ftdata_d = ftdata;
        case (state)
            IDLE: begin
                wr_n_d = 1'b1;
                if (rinc) begin
                    wr_n_d = 1'b0;
                    if (hdr_next) begin
                        state_d  = HDR0;
                        ftdata_d = SYNC0;
                    end else begin
                        state_d  = BYTE_HI;
                        ftdata_d = rdata[15:8];
                    end
                end
            end
            HDR0: if (accept) begin
                state_d  = HDR1;
                ftdata_d = SYNC1;
            end
            HDR1: if (accept) begin
                state_d  = HDR2;
                ftdata_d = line16[15:8];
            end
            HDR2: if (accept) begin
                state_d  = HDR3;
                ftdata_d = line16[7:0];
            end
            HDR3: if (accept) begin
                state_d  = BYTE_HI;
                ftdata_d = word_q[15:8];
            end
            BYTE_HI: if (accept) begin
                state_d  = BYTE_LO;
                ftdata_d = word_q[7:0];
            end
            BYTE_LO: if (accept) begin
                if (rinc) begin
                    // back-to-back word: keep wr_n low, no bubble
                    if (hdr_next) begin
                        state_d  = HDR0;
                        ftdata_d = SYNC0;
                    end else begin
                        state_d  = BYTE_HI;
                        ftdata_d = rdata[15:8];
                    end
                end else begin
                    state_d = IDLE;
                    wr_n_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                wr_n_d  = 1'b1;
            end
        endcase
    end

    // Output logic: pop only when idle (and out of reset for a cycle) or on
    // the edge that accepts the low byte of the current word.
    always_comb begin
        rinc = 1'b0;
        if (fetch) begin
            if (state == IDLE) begin
                rinc = run_q;
            end else if (state == BYTE_LO) begin
                rinc = accept;
            end
        end
    end

endmodule
